bpu_table_predictor: RTL and testbench
======================================

# bpu_table_predictor

Parametrised successor to the pipeline's two-counter branch predictor. A PC-indexed table of 2-bit saturating counters and a bounded FIFO of in-flight predictions together predict conditional branches at fetch and repair mispredictions at execute. Sits beside the fetch stage: it drives the PC-select override and the fetch/decode flush, and consumes branch resolution from execute.

## Interface
- `DATA_WIDTH`, 32, PC and instruction width
- `IDX_BITS`, 6, counter table holds 2^IDX_BITS entries
- `QUEUE_DEPTH`, 4, maximum in-flight predicted branches; power of two, ≥2
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `RD` in DATA_WIDTH: instruction at fetch
- `PCF` in DATA_WIDTH: fetch PC
- `ZeroE` in 1: actual outcome of the resolving branch, 1 = taken
- `JumpE` in 1: jump in execute; suppresses fetch-side prediction
- `BranchE` in 1: conditional branch resolving in execute this cycle
- `flushBranch` out 1: flush younger stages on mispredict
- `PCBPU` out DATA_WIDTH: override next PC
- `PCBPUSrc` out 1: select `PCBPU` as next PC
- `bpuStall` out 1: stall fetch because a branch is at fetch and the queue is full

## Operation
- Fetch branch: `fetchBr` = (`RD[6:0]`==7'b1100011) && !`JumpE`.
- Table index: `idx` = `PCF[IDX_BITS+1:2]`. Prediction is `table[idx][1]`.
- Target: `PCF` + sign-extended B-immediate {RD[31], RD[7], RD[30:25], RD[11:8], 0}, modulo 2^DATA_WIDTH.
- Queue entry fields: branch PC, target, `idx`, prediction (plus GHR snapshot when configured).
- Enqueue condition: `fetchBr` && count<QUEUE_DEPTH && !mispredict. When it holds:
  - Push the entry.
  - Drive `PCBPUSrc`=prediction and `PCBPU`=target.
- Full queue: when `fetchBr` && count==QUEUE_DEPTH, assert `bpuStall`. No enqueue, `PCBPUSrc`=0.
- Resolve: when `BranchE` && count>0, pop the front entry.
  - Mispredict is entry prediction != `ZeroE`.
  - On mispredict: `flushBranch`=1, `PCBPUSrc`=1, `PCBPU` = `ZeroE` ? target : PC+4.
  - On mispredict, the whole queue is cleared at the clock edge, because remaining entries are younger and wrong-path.
- Counter update on every resolve, at the entry's stored `idx`. Saturating: taken increments up to 2'b11, not-taken decrements down to 2'b00.
- `BranchE` with an empty queue is ignored: no pop, no flush, no update.
- Priority: a resolve redirect overrides fetch-side `PCBPU`/`PCBPUSrc`. A mispredict also suppresses the same-cycle enqueue and deasserts `bpuStall`.
- Pointers wrap modulo QUEUE_DEPTH.
- Simultaneous push and pop without mispredict leaves count unchanged. This is legal when full: the pop frees the slot in the same cycle, so `bpuStall`=0.

## Timing
- Outputs are combinational from current state and inputs. Zero-cycle latency from `RD`/`PCF` to prediction.
- Table, queue and count update on the rising edge.
- Same-cycle lookup and update of one index: the lookup sees the pre-update value (no bypass).
- Reset is synchronous:
  - Counters go to 2'b10 (weakly taken), queue to empty, count 0, GHR 0.
  - While `rst`=1, all outputs are 0.
  - Reset mid-operation discards in-flight entries. No flush is issued.
- Queue behaviour at the boundaries:
  - Count ranges 0..QUEUE_DEPTH.
  - Count saturates at neither boundary under normal flow. Illegal push/pop are blocked by the conditions above.

## Configuration
- `BPU_GSHARE_EN` defined:
  - An IDX_BITS-wide global history register (GHR) is kept.
  - Index becomes `PCF[IDX_BITS+1:2]` XOR GHR.
  - GHR shifts in `ZeroE` at each resolve. History is non-speculative.
  - The enqueued entry carries its index, so the counter update targets the index used at predict time.
- Undefined: no GHR, pure PC indexing, entries carry no history.

## Test plan
- Reset, then forward `beq` at PCF=0x100 with imm +16: `PCBPUSrc`=1, `PCBPU`=0x110, count=1.
- Resolve the above with `BranchE`=1, `ZeroE`=0 next cycle: `flushBranch`=1, `PCBPU`=0x104, counter for idx 0 becomes 2'b01, queue empty.
- Same branch again with counter at 2'b01: prediction 0. Resolve not-taken: no flush, counter 2'b00. A further not-taken stays 2'b00.
- Fill the queue with 4 branches, present a 5th: `bpuStall`=1.
  - Assert a correct `BranchE` in the same cycle: `bpuStall`=0 and the 5th is enqueued, count stays 4.
- 3 queued branches, oldest mispredicts while a new branch is at fetch: flush asserted, no enqueue, count=0 next cycle.
- With `BPU_GSHARE_EN`, after GHR=6'b000001, a branch at PCF=0x100 indexes counter 1.
  - Its resolve updates counter 1 even though GHR changed before the resolve.

Source files
------------

// File: rtl/bpu_table_predictor.sv
// PC-indexed 2-bit counter branch predictor with a bounded FIFO of in-flight predictions.
// Optional gshare indexing is enabled with `define BPU_GSHARE_EN.
module bpu_table_predictor #(
    parameter int DATA_WIDTH  = 32,
    parameter int IDX_BITS    = 6,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RD,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic                  ZeroE,
    input  logic                  JumpE,
    input  logic                  BranchE,
    output logic                  flushBranch,
    output logic [DATA_WIDTH-1:0] PCBPU,
    output logic                  PCBPUSrc,
    output logic                  bpuStall
);

    localparam int TBL_N = 2 ** IDX_BITS;
    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QUEUE_DEPTH);

    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken && ctr != 2'b11)
            nxt = ctr + 2'b01;
        else if (!taken && ctr != 2'b00)
            nxt = ctr - 2'b01;
        return nxt;
    endfunction

    logic [1:0]            ctr_tbl [TBL_N];
    logic [DATA_WIDTH-1:0] q_pc    [QUEUE_DEPTH];
    logic [DATA_WIDTH-1:0] q_tgt   [QUEUE_DEPTH];
    logic [IDX_BITS-1:0]   q_idx   [QUEUE_DEPTH];
    logic                  q_pred  [QUEUE_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

`ifdef BPU_GSHARE_EN
    logic [IDX_BITS-1:0] ghr;
`endif

    logic                         fetch_br;
    logic [IDX_BITS-1:0]          idx_f;
    logic                         pred_f;
    logic signed [DATA_WIDTH-1:0] b_imm;
    logic [DATA_WIDTH-1:0]        target_f;
    logic                         resolve;
    logic                         mispredict;
    logic                         enq;
    logic                         pop;
    logic                         stall_c;

    assign fetch_br = (RD[6:0] == 7'b1100011) && !JumpE;

`ifdef BPU_GSHARE_EN
    assign idx_f = PCF[IDX_BITS+1:2] ^ ghr;
`else
    assign idx_f = PCF[IDX_BITS+1:2];
`endif

    assign pred_f   = ctr_tbl[idx_f][1];
    assign b_imm    = signed'({{(DATA_WIDTH-13){RD[31]}}, RD[31], RD[7], RD[30:25], RD[11:8], 1'b0});
    assign target_f = PCF + DATA_WIDTH'(b_imm);

    // A full queue can still accept a branch when the head retires correctly this cycle.
    assign resolve    = BranchE && (count != '0);
    assign mispredict = resolve && (q_pred[rd_ptr] != ZeroE);
    assign pop        = resolve && !mispredict;
    assign enq        = fetch_br && !mispredict && ((count < FULL_CNT) || resolve);
    assign stall_c    = fetch_br && (count == FULL_CNT) && !resolve;

    always_comb begin
        flushBranch = 1'b0;
        PCBPU       = '0;
        PCBPUSrc    = 1'b0;
        bpuStall    = 1'b0;
        if (!rst) begin
            if (mispredict) begin
                flushBranch = 1'b1;
                PCBPUSrc    = 1'b1;
                PCBPU       = ZeroE ? q_tgt[rd_ptr] : (q_pc[rd_ptr] + DATA_WIDTH'(4));
            end else begin
                if (enq) begin
                    PCBPUSrc = pred_f;
                    PCBPU    = target_f;
                end
                bpuStall = stall_c;
            end
        end
    end

    // Control state: counters, pointers, occupancy and history.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TBL_N; i++)
                ctr_tbl[i] <= 2'b10;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
`ifdef BPU_GSHARE_EN
            ghr    <= '0;
`endif
        end else begin
            if (resolve) begin
                ctr_tbl[q_idx[rd_ptr]] <= sat_update(ctr_tbl[q_idx[rd_ptr]], ZeroE);
`ifdef BPU_GSHARE_EN
                ghr <= {ghr[IDX_BITS-2:0], ZeroE};
`endif
            end
            if (mispredict) begin
                // Everything still queued is younger than the mispredicted branch.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                case ({enq, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue payload: written only on enqueue, never reset.
    always_ff @(posedge clk) begin
        if (enq && !rst) begin
            q_pc[wr_ptr]   <= PCF;
            q_tgt[wr_ptr]  <= target_f;
            q_idx[wr_ptr]  <= idx_f;
            q_pred[wr_ptr] <= pred_f;
        end
    end

endmodule

// File: tb/tb_bpu_table_predictor.sv
// Scoreboard bench for bpu_table_predictor: a behavioural model pushes expected outputs per cycle.
module tb_bpu_table_predictor;

    localparam int DW = 32;
    localparam int IB = 6;
    localparam int QD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] RD, PCF;
    logic          ZeroE, JumpE, BranchE;
    logic          flushBranch, PCBPUSrc, bpuStall;
    logic [DW-1:0] PCBPU;

    bpu_table_predictor #(.DATA_WIDTH(DW), .IDX_BITS(IB), .QUEUE_DEPTH(QD)) dut (
        .clk(clk), .rst(rst), .RD(RD), .PCF(PCF), .ZeroE(ZeroE), .JumpE(JumpE),
        .BranchE(BranchE), .flushBranch(flushBranch), .PCBPU(PCBPU),
        .PCBPUSrc(PCBPUSrc), .bpuStall(bpuStall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          flush;
        logic [DW-1:0] pc;
        logic          src;
        logic          stall;
    } exp_t;

    typedef struct {
        logic [DW-1:0] pc;
        logic [DW-1:0] tgt;
        logic [IB-1:0] idx;
        logic          pred;
    } ent_t;

    exp_t       sb[$];
    ent_t       mq[$];
    logic [1:0] mtbl [2**IB];
    logic [IB-1:0] mghr;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_beq(input int imm);
        logic [12:0] b;
        b = imm[12:0];
        return {b[12], b[10:5], 5'd1, 5'd2, 3'b000, b[4:1], b[11], 7'b1100011};
    endfunction

    localparam logic [31:0] NOP = 32'h0000_0013;

    task automatic model_reset();
        for (int i = 0; i < 2**IB; i++) mtbl[i] = 2'b10;
        mq.delete();
        mghr = '0;
    endtask

    // One cycle: drive, predict, compare at negedge, advance the model to the edge.
    task automatic cycle(input logic r, input logic [31:0] rd, input logic [31:0] pcf,
                         input logic z, input logic j, input logic br);
        exp_t e;
        ent_t n, h;
        logic fb, res, mp, enq;
        logic [IB-1:0] idx;
        logic signed [12:0] im13;
        rst = r; RD = rd; PCF = pcf; ZeroE = z; JumpE = j; BranchE = br;

        fb   = (rd[6:0] == 7'b1100011) && !j;
`ifdef BPU_GSHARE_EN
        idx  = pcf[IB+1:2] ^ mghr;
`else
        idx  = pcf[IB+1:2];
`endif
        im13 = {rd[31], rd[7], rd[30:25], rd[11:8], 1'b0};
        n.pc = pcf; n.idx = idx; n.pred = mtbl[idx][1];
        n.tgt = pcf + {{19{im13[12]}}, im13};
        res = br && (mq.size() > 0);
        h   = res ? mq[0] : n;
        mp  = res && (h.pred != z);
        enq = fb && !mp && (mq.size() < QD || res);

        e = '{flush: 1'b0, pc: '0, src: 1'b0, stall: 1'b0};
        if (!r) begin
            if (mp) begin
                e.flush = 1'b1; e.src = 1'b1;
                e.pc = z ? h.tgt : h.pc + 32'd4;
            end else begin
                if (enq) begin e.src = n.pred; e.pc = n.tgt; end
                e.stall = fb && (mq.size() == QD) && !res;
            end
        end
        sb.push_back(e);

        @(negedge clk);
        e = sb.pop_front();
        check("flushBranch", 64'(flushBranch), 64'(e.flush));
        check("PCBPU", 64'(PCBPU), 64'(e.pc));
        check("PCBPUSrc", 64'(PCBPUSrc), 64'(e.src));
        check("bpuStall", 64'(bpuStall), 64'(e.stall));

        if (r) begin
            model_reset();
        end else begin
            if (res) begin
                if (z && mtbl[h.idx] != 2'b11) mtbl[h.idx] = mtbl[h.idx] + 2'b01;
                if (!z && mtbl[h.idx] != 2'b00) mtbl[h.idx] = mtbl[h.idx] - 2'b01;
                mghr = {mghr[IB-2:0], z};
                void'(mq.pop_front());
            end
            if (mp) mq.delete();
            else if (enq) mq.push_back(n);
        end

        @(posedge clk);
        #1;
        check("count", 64'(dut.count), 64'(mq.size()));
    endtask

    initial begin
        rst = 1'b1; RD = NOP; PCF = '0; ZeroE = 1'b0; JumpE = 1'b0; BranchE = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // Reset, including a branch presented while reset is held.
        cycle(1, NOP, 32'h0, 0, 0, 0);
        cycle(1, enc_beq(16), 32'h100, 1, 0, 1);

        // Forward beq predicted taken, then resolved not-taken.
        cycle(0, enc_beq(16), 32'h100, 0, 0, 0);
        check("first_target", 64'(mq.size()), 64'd1);
        cycle(0, NOP, 32'h104, 0, 0, 1);
        check("ctr0_after_nt", 64'(dut.ctr_tbl[0]), 64'd1);

        // Weakly not-taken now: no flush on not-taken, counter saturates at 0.
        cycle(0, enc_beq(16), 32'h100, 0, 0, 0);
        cycle(0, NOP, 32'h104, 0, 0, 1);
        cycle(0, enc_beq(16), 32'h100, 0, 0, 0);
        cycle(0, NOP, 32'h104, 0, 0, 1);
        check("ctr0_sat_low", 64'(dut.ctr_tbl[0]), 64'd0);

        // Fill the queue, stall the fifth, then retire one to admit it.
        for (int i = 0; i < 4; i++)
            cycle(0, enc_beq(-8), 32'h140 + 32'(4 * i), 0, 0, 0);
        cycle(0, enc_beq(-8), 32'h150, 0, 0, 0);
        cycle(0, enc_beq(-8), 32'h150, 1, 0, 1);
        check("full_count", 64'(dut.count), 64'd4);

        // Retire one correctly, then the oldest mispredicts with a branch at fetch.
        cycle(0, NOP, 32'h154, 1, 0, 1);
        cycle(0, enc_beq(32), 32'h200, 0, 0, 1);
        check("flush_clears", 64'(dut.count), 64'd0);

        // Jump suppresses fetch prediction; resolve on empty queue is ignored.
        cycle(0, enc_beq(16), 32'h180, 0, 1, 0);
        cycle(0, NOP, 32'h184, 0, 0, 1);

        // Random mix with aliasing PCs.
        for (int k = 0; k < 300; k++) begin
            logic [31:0] rd, pc;
            int imm;
            imm = $urandom_range(0, 3) == 0 ? -($urandom_range(1, 512) * 2) : $urandom_range(1, 512) * 2;
            rd  = ($urandom_range(0, 2) != 0) ? enc_beq(imm) : NOP;
            pc  = 32'h100 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3) << 8);
            cycle(0, rd, pc, 1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                  1'($urandom_range(0, 1)));
        end

        // Reset mid-operation discards entries without a flush.
        cycle(0, enc_beq(16), 32'h300, 0, 0, 0);
        cycle(0, enc_beq(16), 32'h304, 0, 0, 0);
        cycle(1, NOP, 32'h308, 0, 0, 1);
        cycle(0, NOP, 32'h308, 0, 0, 1);
        check("ctr_reset", 64'(dut.ctr_tbl[0]), 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
